// File: rtl/latch_pkg.sv
// -----------------------------------------------------------------------------
// latch_pkg
// Shared constants and types for the UART command parser.
//   OP_WRITE / OP_READ : command opcodes ('W' / 'R')
//   RSP_ACK / RSP_ERR  : response bytes ('K' after a write, '?' for a bad opcode)
//   parser_state_t     : command parser FSM states
// -----------------------------------------------------------------------------
package latch_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    CAPTURE,
    SEND
  } parser_state_t;

endpackage : latch_pkg

// File: rtl/uart_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser_if
// Byte stream and register-bank signals around the command parser.
//   rx_data/rx_valid            : received byte, one-cycle valid pulse
//   tx_data/tx_valid/tx_ready   : response byte, valid/ready handshake
//   write_en/read_strobe        : register-bank access pulses
//   addr/write_data/read_data   : register-bank address and data
//   timeout                     : pulse when a partial command is discarded
// Modports: master = the parser, slave = UART + register bank side.
// -----------------------------------------------------------------------------
interface uart_cmd_parser_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       write_en;
  logic       read_strobe;
  logic [7:0] addr;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       timeout;

  modport master (
    input  rx_data, rx_valid, tx_ready, read_data,
    output tx_data, tx_valid, write_en, read_strobe, addr, write_data, timeout
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, read_data,
    input  tx_data, tx_valid, write_en, read_strobe, addr, write_data, timeout
  );

endinterface : uart_cmd_parser_if

// File: rtl/uart_cmd_parser_inter_byte_timer.sv
// -----------------------------------------------------------------------------
// inter_byte_timer
// Counts idle clocks between bytes of one command.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : a byte arrived this cycle; restart the count
//   run        : parser is waiting for a further byte of a command
//   expired    : TIMEOUT_CYCLES idle cycles have elapsed (one-cycle pulse)
// -----------------------------------------------------------------------------
module inter_byte_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A byte in the expiry cycle wins, so clear masks expiry.
  always_comb begin
    expired = run && !clear && (cnt_q == LAST);
    cnt_d   = cnt_q + CNT_W'(1);
    if (clear || !run || expired) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule : inter_byte_timer

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Assembles received bytes into 'W' addr data / 'R' addr commands, drives the
// register bank and returns one response byte per command.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_cmd_parser_if.master (rx stream, tx handshake, bank port,
//                timeout pulse)
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_cmd_parser
  import latch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_cmd_parser_if.master  bus
);

  parser_state_t state_q, state_d;
  logic          op_is_write_q, op_is_write_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    write_data_q, write_data_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          write_en_q, write_en_d;
  logic          read_strobe_q, read_strobe_d;
  logic          timeout_q, timeout_d;

  logic          timer_run;
  logic          timer_expired;

  assign timer_run = (state_q == GET_ADDR) || (state_q == GET_DATA);

  inter_byte_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.rx_valid),
    .run     (timer_run),
    .expired (timer_expired)
  );

  // Pulses are set one state early so they appear, registered, in the WRITE /
  // READ state itself.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    op_is_write_d = op_is_write_q;
    addr_d        = addr_q;
    write_data_d  = write_data_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    write_en_d    = 1'b0;
    read_strobe_d = 1'b0;
    timeout_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
            op_is_write_d = (bus.rx_data == OP_WRITE);
            state_d       = GET_ADDR;
          end else begin
            tx_data_d  = RSP_ERR;
            tx_valid_d = 1'b1;
            state_d    = SEND;
          end
        end
      end

      GET_ADDR: begin
        if (bus.rx_valid) begin
          addr_d = bus.rx_data;
          if (op_is_write_q) begin
            state_d = GET_DATA;
          end else begin
            read_strobe_d = 1'b1;
            state_d       = READ;
          end
        end else if (timer_expired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end

      GET_DATA: begin
        if (bus.rx_valid) begin
          write_data_d = bus.rx_data;
          write_en_d   = 1'b1;
          state_d      = WRITE;
        end else if (timer_expired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end

      WRITE: begin
        tx_data_d  = RSP_ACK;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end

      // Bank latches read_data on the strobe; it is usable next cycle.
      READ: state_d = CAPTURE;

      CAPTURE: begin
        tx_data_d  = bus.read_data;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end

      SEND: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_is_write_q <= 1'b0;
      addr_q        <= 8'h00;
      write_data_q  <= 8'h00;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      write_en_q    <= 1'b0;
      read_strobe_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      op_is_write_q <= op_is_write_d;
      addr_q        <= addr_d;
      write_data_q  <= write_data_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      write_en_q    <= write_en_d;
      read_strobe_q <= read_strobe_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.addr        = addr_q;
  assign bus.write_data  = write_data_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.write_en    = write_en_q;
  assign bus.read_strobe = read_strobe_q;
  assign bus.timeout     = timeout_q;

endmodule : uart_cmd_parser

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Command parser FSM between the UART receiver/transmitter and the 256 x 8-bit register bank. It assembles received bytes into write (`'W' addr data`) and read (`'R' addr`) commands, then drives the bank's write and read-strobe controls. It returns one response byte per command through a valid/ready transmit handshake. An inter-byte timeout discards partial commands.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle clocks between bytes of one command. This is 10 ms at 100 MHz. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic is on the posedge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `rx_data`  in  8  received byte; valid only while `rx_valid` = 1.
- `rx_valid`  in  1  single-cycle pulse, one per received byte.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  response available.
- `tx_ready`  in  1  transmitter accepts `tx_data` when `tx_valid` and `tx_ready` are both high at a posedge.
- `write_en`  out  1  register-bank write enable; 1-cycle pulse.
- `read_strobe`  out  1  register-bank read latch; 1-cycle pulse.
- `addr`  out  8  register address.
- `write_data`  out  8  register write value.
- `read_data`  in  8  register-bank read result. Valid in the cycle after `read_strobe`.
- `timeout`  out  1  1-cycle pulse when a partial command is discarded.

## Operation
Decoding:
- Opcodes are `OP_WRITE` = 0x57 ('W') and `OP_READ` = 0x52 ('R').
- Response codes are `RSP_ACK` = 0x4B ('K'), sent after a write, and `RSP_ERR` = 0x3F ('?'), sent for an unknown opcode. A read responds with the register value.

States and transitions:
- IDLE: on `rx_valid`:
  - `OP_WRITE` or `OP_READ`: latch the opcode and go to GET_ADDR.
  - Any other byte: load `tx_data` = `RSP_ERR` and go to SEND.
- GET_ADDR: on `rx_valid`, latch `addr`.
  - Write: go to GET_DATA.
  - Read: go to READ.
- GET_DATA: on `rx_valid`, latch `write_data` and go to WRITE.
- WRITE: assert `write_en` for this one cycle, load `tx_data` = `RSP_ACK`, then go to SEND.
- READ: assert `read_strobe` for this one cycle, then go to CAPTURE.
- CAPTURE: load `tx_data` = `read_data`, then go to SEND.
- SEND: hold `tx_valid` = 1 with `tx_data` stable. On `tx_valid && tx_ready`, go to IDLE.

Timeout:
- A counter clears on every `rx_valid`. It increments in GET_ADDR and GET_DATA only.
- When it reaches `TIMEOUT_CYCLES` - 1 without a byte arriving, the FSM goes to IDLE and pulses `timeout`. No bank access occurs and no response is sent.
- A byte arriving in the same cycle as expiry wins: it is consumed and the counter clears.

Other boundary rules:
- `rx_valid` in WRITE, READ, CAPTURE or SEND is dropped. There is no queuing. The host must wait for each response.
- `addr` 0x00 and 0xFF behave like any other address. There is no wrap or range logic; the address is exactly 8 bits.
- `addr` and `write_data` hold their last values outside access cycles.
- Reset mid-command: all state clears immediately, no `write_en` is produced, and any pending response is lost.

## Timing
- Reset values: `tx_data` = 0x00; `tx_valid`, `write_en`, `read_strobe` and `timeout` = 0; `addr` and `write_data` = 0x00. State is IDLE and the timeout counter is 0.
- Write latency: the data byte's `rx_valid` is at cycle N. `write_en` = 1 in cycle N+1. `tx_valid` rises in cycle N+2.
- Read latency: the address byte's `rx_valid` is at cycle N. `read_strobe` = 1 in cycle N+1. `read_data` is sampled in cycle N+2. `tx_valid` rises in cycle N+3.
- Error latency: a bad opcode at cycle N gives `tx_valid` = 1 from cycle N+1.
- `tx_valid` never drops without a handshake. If `tx_ready` is already high, the handshake completes in the first `tx_valid` cycle. The FSM is back in IDLE the next cycle and accepts a byte there.
- All outputs are registered.

## Structure
- Package `latch_pkg` holds:
  - `OP_WRITE` and `OP_READ`.
  - `RSP_ACK` and `RSP_ERR`.
  - The state enum `parser_state_t` (IDLE, GET_ADDR, GET_DATA, WRITE, READ, CAPTURE, SEND).
- One sub-module, `inter_byte_timer`. It takes parameter `TIMEOUT_CYCLES` and inputs `clear` and `run`, and outputs the 1-cycle `expired` pulse. Its counter width is `$clog2(TIMEOUT_CYCLES)`.

## Test plan
- **Write:** send 0x57 0x10 0xA5 with `tx_ready` = 1. Expect `write_en` for exactly one cycle with `addr` = 0x10 and `write_data` = 0xA5, then `tx_data` = 0x4B.
- **Read-back:** after the write, send 0x52 0x10. Expect one `read_strobe` cycle with `addr` = 0x10, then `tx_data` = 0xA5. Also check read-back of an unwritten address 0xFF after a preload of 0x3C.
- **Bad opcode:** send 0x00. Expect `tx_data` = 0x3F, and no `write_en` or `read_strobe`.
- **Timeout:** with `TIMEOUT_CYCLES` = 16, send 0x57 0x20 then stall 16 cycles. Expect one `timeout` pulse and no `write_en`. A following 0x52 0x20 must parse as a new read.
- **Backpressure:** hold `tx_ready` = 0 for 20 cycles after a read. `tx_valid` and `tx_data` must stay stable, and a byte arriving meanwhile is dropped. Release `tx_ready`: handshake in one cycle, then IDLE.
- **Reset mid-command:** assert `rst_n` = 0 after 0x57 0x30. All outputs go to reset values asynchronously. After release, 0xA5 alone produces `RSP_ERR`, not a write.
